// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a burst of consecutive BRAM words out of an AXI-Stream master.
//
// A burst is requested with start_in (base_addr_in, length_in sampled together). Reads are
// issued to a fixed-latency BRAM under a credit rule: a read is only issued when the output
// FIFO has room for it plus every read still in flight. This means returning data always
// has a slot and never needs back-pressure.
//
// Ports
//   clk_in, rst_n_in           clock, synchronous active-low reset
//   start_in                   one-cycle burst request (only honoured in idle)
//   base_addr_in, length_in    first word address and word count
//   busy_out, done_out         burst in progress / one-cycle completion pulse
//   bram_en_out, bram_addr_out registered BRAM read port
//   bram_dout_in               BRAM read data, valid READ_LATENCY cycles after sampling
//   m_axis_*                   AXI-Stream master (tvalid, tdata, tlast, tready)
module bram_stream_reader #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 33,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [ADDR_WIDTH:0]   length_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  bram_en_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  input  logic [DATA_WIDTH-1:0] bram_dout_in,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned LenW = ADDR_WIDTH + 1;
  localparam logic [CntW:0]   DepthC = (CntW + 1)'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    en_q, en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LenW-1:0]         left_q, left_d;      // reads still to issue
  logic [LenW-1:0]         len_q, len_d;
  logic [LenW-1:0]         pop_cnt_q, pop_cnt_d;
  logic [CntW-1:0]         occ_q, occ_d;
  logic [CntW-1:0]         inflight_q, inflight_d;
  logic [READ_LATENCY-1:0] ret_pipe_q, ret_pipe_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   buf_q [DEPTH];

  logic          ret;
  logic          pop;
  logic [CntW:0] committed;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // The oldest stage marks the cycle in which bram_dout_in belongs to one of our reads.
  assign ret           = ret_pipe_q[READ_LATENCY-1];
  assign m_axis_tvalid = (occ_q != '0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid & (pop_cnt_q == len_q - 1'b1);
  assign m_axis_tdata  = m_axis_tvalid ? buf_q[rd_ptr_q] : '0;
  assign busy_out      = (state_q != StIdle);
  assign done_out      = done_q;
  assign bram_en_out   = en_q;
  assign bram_addr_out = addr_q;

  always_comb begin
    occ_d      = occ_q + CntW'(ret) - CntW'(pop);
    inflight_d = inflight_q + CntW'(en_q) - CntW'(ret);
    // Slots already promised after this edge; the next read needs one more.
    committed  = {1'b0, occ_d} + {1'b0, inflight_d};
    ret_pipe_d = (ret_pipe_q << 1) | READ_LATENCY'(en_q);
    wr_ptr_d   = ret ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    state_d   = state_q;
    en_d      = 1'b0;
    addr_d    = addr_q + ADDR_WIDTH'(en_q);
    left_d    = left_q;
    len_d     = len_q;
    pop_cnt_d = pop_cnt_q + LenW'(pop);
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        // done_q high means this is the completion cycle; a start here is dropped.
        if (start_in && !done_q) begin
          if (length_in != '0) begin
            state_d   = StIssue;
            en_d      = 1'b1;
            addr_d    = base_addr_in;
            left_d    = length_in;
            len_d     = length_in;
            pop_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        left_d = left_q - LenW'(en_q);
        if (left_d == '0) begin
          state_d = StDrain;
        end else begin
          en_d = (committed < DepthC);
        end
      end
      StDrain: begin
        if (pop && m_axis_tlast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      en_q       <= 1'b0;
      addr_q     <= '0;
      left_q     <= '0;
      len_q      <= '0;
      pop_cnt_q  <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      ret_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      len_q      <= len_d;
      pop_cnt_q  <= pop_cnt_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      ret_pipe_q <= ret_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: tdata is masked while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (ret) begin
      buf_q[wr_ptr_q] <= bram_dout_in;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural BRAM, directed bursts, queue-based scoreboard.
module tb_bram_stream_reader;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 33;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [AW:0]   length_in;
  logic          busy_out;
  logic          done_out;
  logic          bram_en_out;
  logic [AW-1:0] bram_addr_out;
  logic [DW-1:0] bram_dout_in;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready;

  always #5 clk_in = ~clk_in;

  bram_stream_reader #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start_in),
    .base_addr_in (base_addr_in),
    .length_in    (length_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .bram_en_out  (bram_en_out),
    .bram_addr_out(bram_addr_out),
    .bram_dout_in (bram_dout_in),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  // BRAM contents: a fixed scramble of the address.
  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = ({20'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    return {a[0] ^ a[7], h};
  endfunction

  // Fixed-latency BRAM; unrequested cycles return junk so untagged data would be caught.
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk_in) begin
    rd_pipe[0] <= bram_en_out ? bram_word(bram_addr_out) : {1'b0, $urandom()};
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bram_dout_in = rd_pipe[RL-1];

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int tlast_cnt   = 0;
  int done_base   = 0;
  int tlast_base  = 0;
  int issued      = 0;
  int popped      = 0;
  int max_out     = 0;
  int cyc         = 0;

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            beat_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy_out, done_out, bram_en_out, bram_addr_out,
                m_axis_tvalid, m_axis_tdata, m_axis_tlast});
  endfunction

  // Monitor: checks every BRAM read and every stream beat against the queues.
  initial begin
    bit            exp_done = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_n_in) begin
        exp_done   = 0;
        prev_stall = 0;
      end else begin
        if (exp_done) chk("done_after_tlast", {busy_out, done_out}, 2'b01);
        exp_done = 0;
        if (done_out) done_cnt++;
        if (bram_en_out) begin
          issued++;
          if (addr_q.size() == 0) chk("unexpected_read", bram_addr_out, 0);
          else chk("read_addr", bram_addr_out, addr_q.pop_front());
          if (issued - popped > max_out) max_out = issued - popped;
        end
        if (prev_stall) begin
          chk("held_while_stalled", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
              {1'b1, prev_last, prev_data});
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
          popped++;
          beat_cyc.push_back(cyc);
          if (exp_q.size() == 0) chk("unexpected_beat", {m_axis_tlast, m_axis_tdata}, 0);
          else chk("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
          if (m_axis_tlast) begin
            tlast_cnt++;
            exp_done = 1;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] len);
    @(posedge clk_in); #1;
    start_in     = 1'b1;
    base_addr_in = base;
    length_in    = len;
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back({(i == int'(len) - 1), bram_word(a)});
    end
    done_base  = done_cnt;
    tlast_base = tlast_cnt;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  // mode 0: tready high; 1: tready low for cycles 5..20; 2: random tready.
  task automatic run_burst(input int mode, input int max_cyc, input bit inject);
    bit seen = 0;
    for (int c = 1; c <= max_cyc && !seen; c++) begin
      @(posedge clk_in); #1;
      start_in = 1'b0;
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = !(c >= 5 && c <= 20);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk_in); #1;
      if (done_cnt != done_base) begin
        seen = 1;
        if (inject) begin
          // Offered exactly in the done_out cycle; must be dropped.
          start_in     = 1'b1;
          base_addr_in = 12'h040;
          length_in    = 13'd2;
        end
      end
    end
    chk("burst_completed", seen, 1);
    if (inject) begin
      @(posedge clk_in); #1;
      start_in = 1'b0;
    end
    m_axis_tready = 1'b1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("reads_drained", addr_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n_in      = 1'b0;
    start_in      = 1'b0;
    base_addr_in  = '0;
    length_in     = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); #1;
    chk("reset_outputs", outs(), 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);

    // Basic burst: first-read and first-beat latency, back-to-back beats.
    beat_cyc.delete();
    do_start(12'h010, 13'd8);
    @(negedge clk_in); #1;
    chk("first_read_cycle", {bram_en_out, m_axis_tvalid}, 2'b10);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin
      @(negedge clk_in); #1;
      n++;
    end
    chk("first_beat_latency", n, RL + 1);
    run_burst(0, 100, 1);
    chk("beat_count", beat_cyc.size(), 8);
    if (beat_cyc.size() >= 8) chk("no_bubbles", beat_cyc[7] - beat_cyc[0], 7);
    chk("single_tlast", tlast_cnt - tlast_base, 1);
    repeat (6) @(posedge clk_in); #1;
    chk("start_during_done_ignored", busy_out, 0);

    // Address wrap.
    do_start(12'hFFE, 13'd4);
    run_burst(0, 100, 0);

    // Long stall: credit limit must cap outstanding reads.
    issued  = 0;
    popped  = 0;
    max_out = 0;
    do_start(12'h300, 13'd16);
    run_burst(1, 300, 0);
    chk("max_outstanding", max_out, DEPTH);

    // Random back-pressure.
    do_start(12'h400, 13'd100);
    run_burst(2, 3000, 0);
    chk("one_tlast_random", tlast_cnt - tlast_base, 1);
    chk("one_done_random", done_cnt - done_base, 1);

    // Zero-length request.
    do_start(12'h123, 13'd0);
    @(negedge clk_in); #1;
    chk("len0_done_pulse", {busy_out, done_out}, 2'b01);
    repeat (8) @(posedge clk_in); #1;
    chk("len0_done_count", done_cnt - done_base, 1);
    chk("len0_idle", {busy_out, bram_en_out, m_axis_tvalid}, 0);

    // Reset mid-burst with reads in flight, then a fresh burst.
    do_start(12'h500, 13'd16);
    repeat (4) @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    exp_q.delete();
    addr_q.delete();
    issued = 0;
    popped = 0;
    @(negedge clk_in); #1;
    chk("post_reset_outputs", outs(), 0);
    repeat (10) @(posedge clk_in);
    do_start(12'h7F0, 13'd3);
    run_burst(0, 100, 0);
    chk("post_reset_one_done", done_cnt - done_base, 1);

    repeat (3) @(posedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
